// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit with HI/LO. The result is computed at start and
// held in pend_hi/pend_lo; busy models the datapath latency for the stall logic.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

    md_state_e   state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;

    logic signed [63:0] a_s, b_s, q_s, r_s;
    logic [63:0] res;
    logic [3:0]  lat;
    logic        is_md;

    assign a_s = {{32{rs_val[31]}}, rs_val};
    assign b_s = {{32{rt_val[31]}}, rt_val};

    // Signed divide is done at 64 bits so 0x80000000 / -1 cannot overflow;
    // a zero divisor re-commits the current HI/LO.
    always_comb begin
        res   = {hi, lo};
        lat   = MULT_LAST;
        is_md = 1'b1;
        q_s   = '0;
        r_s   = '0;
        case (md_op_e'(op))
            MD_MULT:  res = a_s * b_s;
            MD_MULTU: res = {32'd0, rs_val} * {32'd0, rt_val};
            MD_DIV: begin
                lat = DIV_LAST;
                if (rt_val != 32'd0) begin
                    q_s = a_s / b_s;
                    r_s = a_s % b_s;
                    res = {r_s[31:0], q_s[31:0]};
                end
            end
            MD_DIVU: begin
                lat = DIV_LAST;
                if (rt_val != 32'd0)
                    res = {rs_val % rt_val, rs_val / rt_val};
            end
            default:  is_md = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_md) begin
                            pend_hi <= res[63:32];
                            pend_lo <= res[31:0];
                            cnt     <= lat;
                            state   <= ST_BUSY;
                            busy    <= 1'b1;
                        end else if (md_op_e'(op) == MD_MTHI) begin
                            hi <= rs_val;
                        end else if (md_op_e'(op) == MD_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == 4'd0) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
